ps2_rx_fifo: RTL
================

Name: ps2_rx_fifo

Overview:
Parametrised PS/2 keyboard receiver for the 8-bit computer. It replaces the raw bit-counter capture of PS2_DAT with a filtered, frame-checked receiver. Decoded scan codes are buffered in a FIFO with a ready/valid read port, which the CPU-side address decode or the LED debug logic consumes. Error and overflow status are reported alongside.

Parameters:
FIFO_DEPTH, 16, number of scan-code entries; power of 2, >=2
FILTER_LEN, 8, consecutive equal CLOCK_50 samples required before filtered PS2_CLK/PS2_DAT change
TIMEOUT_CYCLES, 50000, CLOCK_50 cycles with no falling PS2_CLK edge before a partial frame is aborted (1 ms)

Ports:
CLOCK_50  in  1  system clock, 50 MHz; all state on posedge
res  in  1  asynchronous, active-low reset
PS2_CLK  in  1  raw PS/2 clock from connector, asynchronous
PS2_DAT  in  1  raw PS/2 data from connector, asynchronous
rd_data  out  8  scan code at FIFO head
rd_brk  out  1  head entry is a break code (0 unless PS2_MAKE_BREAK_EN)
rd_ext  out  1  head entry is an E0-extended code (0 unless PS2_MAKE_BREAK_EN)
rd_valid  out  1  FIFO non-empty
rd_ready  in  1  consumer pop; pop occurs when rd_valid & rd_ready
count  out  $clog2(FIFO_DEPTH+1)  current occupancy
err_parity  out  1  one-cycle pulse on parity failure
err_frame  out  1  one-cycle pulse on bad stop bit or timeout
ovf  out  1  sticky; set when a good frame is dropped because the FIFO is full
clr_ovf  in  1  synchronous clear of ovf

Behaviour:
- Reset (async, res=0): all outputs 0. FIFO empty, FSM in IDLE, filters preset to 1, timeout counter 0. Reset mid-frame discards the partial frame.
- Input path: 2-flop synchroniser on each of PS2_CLK and PS2_DAT, followed by the FILTER_LEN glitch filter. A filtered PS2_CLK 1->0 transition produces a one-cycle sample strobe that captures filtered PS2_DAT.
- FSM states (advance only on a sample strobe):
  - IDLE: data=0 -> DATA with bit index 0; data=1 -> stay in IDLE.
  - DATA: shift bits LSB first; after bit 7 -> PARITY.
  - PARITY: capture parity bit -> STOP.
  - STOP: check the frame -> IDLE.
- Frame check in STOP:
  - Stop bit must be 1; otherwise err_frame pulses.
  - Odd parity: XOR of data and parity must be 1; otherwise err_parity pulses.
  - If both fail, both pulse in the same cycle.
  - A good frame pushes one entry in the cycle after the STOP strobe.
- Timeout: counter clears on every strobe and counts while FSM != IDLE. On reaching TIMEOUT_CYCLES: FSM -> IDLE, err_frame pulses, nothing is pushed.
- FIFO:
  - Show-ahead: rd_data/rd_brk/rd_ext are valid whenever rd_valid=1.
  - Push into an empty FIFO: rd_valid=1 on the following cycle.
  - Pop: head advances next cycle; count decrements.
  - Push while full with no simultaneous pop: entry dropped, ovf set, count stays FIFO_DEPTH.
  - Push while full with simultaneous pop: both are accepted, count unchanged, no ovf.
  - Push and pop together at any occupancy: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- ovf: cleared only by clr_ovf or reset. If clr_ovf and a new overflow occur in the same cycle, ovf stays 1.
- rd_ready while empty: ignored.

Optional Feature:
PS2_MAKE_BREAK_EN
- Defined:
  - Good frames of 0xE0 set a pending ext flag and are not pushed.
  - Good frames of 0xF0 set a pending brk flag and are not pushed.
  - The next other good code is pushed as {ext,brk,code}, after which both pending flags clear.
  - Pending flags also clear on err_parity, err_frame, or reset.
  - FIFO entries are 10 bits wide.
- Undefined: every good byte is pushed unchanged, entries are 8 bits, and rd_brk=rd_ext=0.

Test Plan:
1. Frame 0x1C, parity 0, stop 1, bit period 60 us -> rd_valid=1, rd_data=0x1C, count=1. Pop -> rd_valid=0, count=0.
2. Frame 0x1C with parity 1 -> err_parity single pulse, count stays 0. Following frame 0x5A with parity 1 -> received correctly.
3. 17 good frames 0x00..0x10, no pops, FIFO_DEPTH=16 -> count=16, ovf=1. Read back 0x00..0x0F in order. clr_ovf -> ovf=0.
4. Start bit plus 4 data bits, then PS2_CLK held high for 1.2 ms -> err_frame pulse, count=0. Next frame 0x5A -> rd_data=0x5A.
5. With FILTER_LEN=8: a 3-cycle low glitch on PS2_CLK in IDLE and mid-frame -> no strobe, no error, and frame 0x29 is received intact.
6. With PS2_MAKE_BREAK_EN: frames E0, F0, 6B -> single entry rd_data=0x6B, rd_brk=1, rd_ext=1. Then frame 1C -> entry 0x1C with brk=ext=0.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: filtered, frame-checked PS/2 keyboard receiver with a
// show-ahead scan-code FIFO and a ready/valid read port.
//
// Ports:
//   CLOCK_50            system clock, all state on posedge
//   res                 asynchronous active-low reset
//   PS2_CLK, PS2_DAT    raw asynchronous PS/2 lines from the connector
//   rd_data/rd_brk/rd_ext  head entry (valid while rd_valid)
//   rd_valid, rd_ready  FIFO non-empty / consumer pop
//   count               current FIFO occupancy
//   err_parity          one-cycle pulse on odd-parity failure
//   err_frame           one-cycle pulse on bad stop bit or frame timeout
//   ovf, clr_ovf        sticky overflow flag and its synchronous clear
//
// Optional feature macro: PS2_MAKE_BREAK_EN folds E0/F0 prefix bytes into
// ext/brk flags on the following code (10-bit FIFO entries).
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH     = 16,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                              CLOCK_50,
  input  logic                              res,
  input  logic                              PS2_CLK,
  input  logic                              PS2_DAT,
  output logic [7:0]                        rd_data,
  output logic                              rd_brk,
  output logic                              rd_ext,
  output logic                              rd_valid,
  input  logic                              rd_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
  output logic                              err_parity,
  output logic                              err_frame,
  output logic                              ovf,
  input  logic                              clr_ovf
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
`ifdef PS2_MAKE_BREAK_EN
  localparam int EW  = 10;
`else
  localparam int EW  = 8;
`endif

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // Synchronisers and glitch filters (idle-high lines, preset to 1)
  logic [1:0]     clk_sync, dat_sync;
  logic           clk_flt, dat_flt, clk_flt_q;
  logic [FCW-1:0] clk_fcnt, dat_fcnt;
  logic           strobe;

  always_ff @(posedge CLOCK_50 or negedge res) begin
    if (!res) begin
      clk_sync  <= '1;
      dat_sync  <= '1;
      clk_flt   <= 1'b1;
      dat_flt   <= 1'b1;
      clk_flt_q <= 1'b1;
      clk_fcnt  <= '0;
      dat_fcnt  <= '0;
    end else begin
      clk_sync  <= {clk_sync[0], PS2_CLK};
      dat_sync  <= {dat_sync[0], PS2_DAT};
      clk_flt_q <= clk_flt;
      // Filtered value follows only after FILTER_LEN consecutive differing samples
      if (clk_sync[1] == clk_flt) begin
        clk_fcnt <= '0;
      end else if (clk_fcnt == FCW'(FILTER_LEN - 1)) begin
        clk_flt  <= clk_sync[1];
        clk_fcnt <= '0;
      end else begin
        clk_fcnt <= clk_fcnt + FCW'(1);
      end
      if (dat_sync[1] == dat_flt) begin
        dat_fcnt <= '0;
      end else if (dat_fcnt == FCW'(FILTER_LEN - 1)) begin
        dat_flt  <= dat_sync[1];
        dat_fcnt <= '0;
      end else begin
        dat_fcnt <= dat_fcnt + FCW'(1);
      end
    end
  end

  assign strobe = clk_flt_q & ~clk_flt;

  // Frame receiver
  state_t        state;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          par_bit;
  logic [TW-1:0] tcnt;
  logic          push_req;
  logic [EW-1:0] push_data;
  logic          par_ok;
`ifdef PS2_MAKE_BREAK_EN
  logic          brk_pend, ext_pend;
`endif

  assign par_ok = ^{shift, par_bit};

  always_ff @(posedge CLOCK_50 or negedge res) begin
    if (!res) begin
      state      <= S_IDLE;
      bit_idx    <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      tcnt       <= '0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
      push_req   <= 1'b0;
      push_data  <= '0;
`ifdef PS2_MAKE_BREAK_EN
      brk_pend   <= 1'b0;
      ext_pend   <= 1'b0;
`endif
    end else begin
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
      push_req   <= 1'b0;
      if (strobe) begin
        tcnt <= '0;
        case (state)
          S_IDLE: begin
            if (!dat_flt) begin
              state   <= S_DATA;
              bit_idx <= '0;
            end
          end
          S_DATA: begin
            shift   <= {dat_flt, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= S_PARITY;
          end
          S_PARITY: begin
            par_bit <= dat_flt;
            state   <= S_STOP;
          end
          S_STOP: begin
            state      <= S_IDLE;
            err_frame  <= ~dat_flt;
            err_parity <= ~par_ok;
            if (dat_flt && par_ok) begin
`ifdef PS2_MAKE_BREAK_EN
              if (shift == 8'hE0) begin
                ext_pend <= 1'b1;
              end else if (shift == 8'hF0) begin
                brk_pend <= 1'b1;
              end else begin
                push_req  <= 1'b1;
                push_data <= {ext_pend, brk_pend, shift};
                ext_pend  <= 1'b0;
                brk_pend  <= 1'b0;
              end
`else
              push_req  <= 1'b1;
              push_data <= shift;
`endif
            end else begin
`ifdef PS2_MAKE_BREAK_EN
              ext_pend <= 1'b0;
              brk_pend <= 1'b0;
`endif
            end
          end
          default: state <= S_IDLE;
        endcase
      end else if (state != S_IDLE) begin
        if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
          state     <= S_IDLE;
          tcnt      <= '0;
          err_frame <= 1'b1;
`ifdef PS2_MAKE_BREAK_EN
          ext_pend  <= 1'b0;
          brk_pend  <= 1'b0;
`endif
        end else begin
          tcnt <= tcnt + TW'(1);
        end
      end
    end
  end

  // Show-ahead FIFO
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [EW-1:0] head;
  logic          full, pop, do_push, drop;

  assign rd_valid = (count != '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign pop      = rd_valid & rd_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept
  assign do_push  = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_ff @(posedge CLOCK_50) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge CLOCK_50 or negedge res) begin
    if (!res) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop)         ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

  assign head    = mem[rd_ptr];
  assign rd_data = rd_valid ? head[7:0] : '0;
`ifdef PS2_MAKE_BREAK_EN
  assign rd_brk  = rd_valid & head[8];
  assign rd_ext  = rd_valid & head[9];
`else
  assign rd_brk  = 1'b0;
  assign rd_ext  = 1'b0;
`endif

endmodule
